// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer and flush-to-NOP.
// Latency: 1 cycle from accept to out_valid when empty; 1 entry/cycle with out_ready held high.
// Backpressure: in_ready is decoded from registered state (low only when both entries are held).
// Optional feature macro: PIPE_STALL_CNT_EN adds a saturating stall_cnt output.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Reject degenerate widths at elaboration time.
  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_skid: DATA_W and CNT_W must be >= 1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;

  logic                w_accept;
  logic                w_drain;
  logic                w_main_nop;
  logic                w_main_from_in;
  logic                w_main_from_skid;
  logic                w_skid_load;

  // Handshake outputs come straight from the state register, so no ready path crosses the stage.
  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = (r_state != ST_TWO);
  assign out_data  = r_main;

  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // Next-state and datapath-load decode; flush overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_main_nop       = 1'b0;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nop  = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_main_from_in = 1'b1;
            w_state_nxt    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_main_from_in = 1'b1;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_TWO;
          end else if (w_drain) begin
            // Main keeps its last payload; out_valid=0 tells downstream to ignore it.
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            w_main_from_skid = 1'b1;
            w_state_nxt      = ST_ONE;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nop  = 1'b1;
        end
      endcase
    end
  end

  // State register; reset lands in EMPTY immediately, without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main/skid payload registers; main shows NOP_VAL after reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main <= NOP_VAL;
      r_skid <= NOP_VAL;
    end else begin
      if (w_main_nop) begin
        r_main <= NOP_VAL;
      end else if (w_main_from_in) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_load) begin
        r_skid <= in_data;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  assign w_stall   = out_valid & ~out_ready;
  assign stall_cnt = r_stall_cnt;

  // Count backpressured cycles, saturating; only reset clears it so flushes keep the history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
`else
`endif

endmodule
